cache_2way_wb: RTL and testbench

- Parametrised two-way set-associative, write-back, write-allocate cache with one data word per line and per-set LRU.
- Sits between a processor-side request port and the backing RAM model.
- Successor to the fixed 4-set, 8-bit two-way cache: adds reads, a valid/ready request handshake, dirty-victim write-back, miss refill over a memory handshake, and reset.

---
 rtl/cache_2way_wb.sv | 187 ++++++++++++++++++
 tb/tb_cache_2way_wb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_2way_wb.sv
// Two-way set-associative write-back, write-allocate cache with one word per line and per-set LRU.
// Optional CACHE_STATS_EN adds saturating 16-bit hit/miss counters.
module cache_2way_wb #(
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [INDEX_W-1:0]       req_index,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [TAG_W+INDEX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
`endif
);

  localparam int unsigned SETS = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    StIdle, StTagCheck, StWriteback, StRefill, StInstall, StResp
  } state_e;

  state_e state_q, state_d;

  logic [SETS-1:0][1:0] valid_q, dirty_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     way_tag_q  [SETS][2];
  logic [DATA_W-1:0]    way_data_q [SETS][2];

  logic               rq_write_q;
  logic [INDEX_W-1:0] rq_index_q;
  logic [TAG_W-1:0]   rq_tag_q;
  logic [DATA_W-1:0]  rq_wdata_q;
  logic               hit_q, victim_q;
  logic [DATA_W-1:0]  word_q;
  logic               resp_valid_q, resp_hit_q;
  logic [DATA_W-1:0]  resp_rdata_q;

  logic [1:0] set_valid, set_dirty, match;
  logic       lookup_hit, hit_way, victim_way, victim_dirty;

  always_comb begin
    set_valid    = valid_q[rq_index_q];
    set_dirty    = dirty_q[rq_index_q];
    match[0]     = set_valid[0] && (way_tag_q[rq_index_q][0] == rq_tag_q);
    match[1]     = set_valid[1] && (way_tag_q[rq_index_q][1] == rq_tag_q);
    lookup_hit   = |match;
    hit_way      = match[1];
    // Fill invalid ways first; the LRU pointer only decides between two valid lines.
    if (!set_valid[0])      victim_way = 1'b0;
    else if (!set_valid[1]) victim_way = 1'b1;
    else                    victim_way = lru_q[rq_index_q];
    victim_dirty = set_valid[victim_way] && set_dirty[victim_way];
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StTagCheck;
      end
      StTagCheck: begin
        if (lookup_hit)        state_d = StResp;
        else if (victim_dirty) state_d = StWriteback;
        else if (rq_write_q)   state_d = StInstall;
        else                   state_d = StRefill;
      end
      StWriteback: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {way_tag_q[rq_index_q][victim_q], rq_index_q};
        mem_wdata = way_data_q[rq_index_q][victim_q];
        if (mem_ack) state_d = rq_write_q ? StInstall : StRefill;
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {rq_tag_q, rq_index_q};
        if (mem_ack) state_d = StInstall;
      end
      StInstall: state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
      rq_write_q   <= 1'b0;
      rq_index_q   <= '0;
      rq_tag_q     <= '0;
      rq_wdata_q   <= '0;
      hit_q        <= 1'b0;
      victim_q     <= 1'b0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_q == StResp);
      if (state_q == StIdle && req_valid) begin
        rq_write_q <= req_write;
        rq_index_q <= req_index;
        rq_tag_q   <= req_tag;
        rq_wdata_q <= req_wdata;
      end
      if (state_q == StTagCheck) begin
        hit_q <= lookup_hit;
        if (lookup_hit) begin
          lru_q[rq_index_q] <= ~hit_way;
          if (rq_write_q) dirty_q[rq_index_q][hit_way] <= 1'b1;
          else            word_q <= way_data_q[rq_index_q][hit_way];
        end else begin
          victim_q <= victim_way;
        end
      end
      if (state_q == StRefill && mem_ack) word_q <= mem_rdata;
      if (state_q == StInstall) begin
        valid_q[rq_index_q][victim_q] <= 1'b1;
        dirty_q[rq_index_q][victim_q] <= rq_write_q;
        lru_q[rq_index_q]             <= ~victim_q;
      end
      if (state_q == StResp) begin
        resp_hit_q   <= hit_q;
        resp_rdata_q <= rq_write_q ? rq_wdata_q : word_q;
      end
    end
  end

  // Tag/data storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge clock) begin
    if (state_q == StTagCheck && lookup_hit && rq_write_q) begin
      way_data_q[rq_index_q][hit_way] <= rq_wdata_q;
    end
    if (state_q == StInstall) begin
      way_tag_q[rq_index_q][victim_q]  <= rq_tag_q;
      way_data_q[rq_index_q][victim_q] <= rq_write_q ? rq_wdata_q : word_q;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_rdata = resp_rdata_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == StTagCheck) begin
      if (lookup_hit && hit_count_q != 16'hFFFF)   hit_count_q  <= hit_count_q + 16'd1;
      if (!lookup_hit && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_2way_wb.sv
// Randomised self-checking bench for cache_2way_wb against a set/way/memory model.
// Directed scenarios first, then random traffic with random memory ack delays.
module tb_cache_2way_wb;

  localparam int SETS = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic       req_ready;
  logic [1:0] req_index = '0;
  logic [7:0] req_tag = '0, req_wdata = '0;
  logic       resp_valid, resp_hit;
  logic [7:0] resp_rdata;
  logic       mem_req, mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_2way_wb dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_index(req_index), .req_tag(req_tag), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference state: what each set holds, plus the backing memory contents.
  bit         mv     [SETS][2];
  bit         mdirty [SETS][2];
  logic [7:0] mt     [SETS][2];
  logic [7:0] md     [SETS][2];
  bit         mlru   [SETS];
  logic [7:0] mem_model [1024];
  int         hits_m, misses_m;

  int n_pass = 0, n_total = 0;

  bit         last_hit;
  logic [7:0] last_rdata, last_wb_data;
  logic [9:0] last_wb_addr, last_rf_addr;
  int         last_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mlru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mv[s][w]     = 1'b0;
        mdirty[s][w] = 1'b0;
      end
    end
    hits_m   = 0;
    misses_m = 0;
  endtask

  task automatic do_req(input bit w, input int idx, input logic [7:0] tg, input logic [7:0] wd,
                        input int dly);
    bit         hit, exp_wb, exp_rf, done;
    int         way, vic, phase, cnt, acc, exp_lat;
    logic [9:0] wb_addr, rf_addr;
    logic [7:0] wb_data, word, exp_rdata;
    @(negedge clock);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_index = idx[1:0];
    req_tag   = tg;
    req_wdata = wd;
    @(posedge clock);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
    req_tag   = 8'($urandom);
    req_wdata = 8'($urandom);

    hit = 1'b0; way = 0; exp_wb = 1'b0; exp_rf = 1'b0;
    wb_addr = '0; wb_data = '0;
    rf_addr = {tg, idx[1:0]};
    for (int k = 0; k < 2; k++) if (mv[idx][k] && mt[idx][k] == tg) begin hit = 1'b1; way = k; end
    if (hit) begin
      hits_m++;
      if (w) begin md[idx][way] = wd; mdirty[idx][way] = 1'b1; end
      exp_rdata = w ? wd : md[idx][way];
      mlru[idx] = (way == 0);
    end else begin
      misses_m++;
      vic = !mv[idx][0] ? 0 : (!mv[idx][1] ? 1 : int'(mlru[idx]));
      if (mv[idx][vic] && mdirty[idx][vic]) begin
        exp_wb = 1'b1;
        wb_addr = {mt[idx][vic], idx[1:0]};
        wb_data = md[idx][vic];
        mem_model[wb_addr] = wb_data;
      end
      exp_rf = !w;
      word = w ? wd : mem_model[rf_addr];
      mv[idx][vic] = 1'b1; mt[idx][vic] = tg; md[idx][vic] = word; mdirty[idx][vic] = w;
      mlru[idx] = (vic == 0);
      exp_rdata = word;
    end
    exp_lat = hit ? 2 : 3 + (int'(exp_wb) + int'(exp_rf)) * (dly + 1);
    phase = exp_wb ? 0 : (exp_rf ? 1 : 2);

    done = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (resp_valid) begin
        chk("resp_hit", 32'(resp_hit), 32'(hit));
        chk("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
        chk("latency", 32'(cyc - acc), 32'(exp_lat));
        chk("mem_done", 32'(phase), 32'd2);
        chk("ready_after", 32'(req_ready), 32'd1);
        last_hit = resp_hit; last_rdata = resp_rdata; last_lat = cyc - acc;
        done = 1'b1;
      end else begin
        chk("busy_ready", 32'(req_ready), 32'd0);
        if (phase == 2) begin
          chk("mem_req_idle", 32'(mem_req), 32'd0);
        end else if (mem_req) begin
          if (phase == 0) begin
            chk("wb_we", 32'(mem_we), 32'd1);
            chk("wb_addr", 32'(mem_addr), 32'(wb_addr));
            chk("wb_data", 32'(mem_wdata), 32'(wb_data));
          end else begin
            chk("rf_we", 32'(mem_we), 32'd0);
            chk("rf_addr", 32'(mem_addr), 32'(rf_addr));
          end
          if (cnt == dly) begin
            mem_ack = 1'b1;
            if (phase == 0) begin
              last_wb_addr = mem_addr; last_wb_data = mem_wdata;
              mem_rdata = 8'($urandom);
              phase = exp_rf ? 1 : 2;
            end else begin
              last_rf_addr = mem_addr;
              mem_rdata = mem_model[rf_addr];
              phase = 2;
            end
            cnt = 0;
          end else begin
            cnt++;
          end
        end
        if (!mem_req) begin
          // Stray acks while no transaction is open must be ignored.
          mem_ack   = 1'($urandom_range(0, 1));
          mem_rdata = 8'($urandom);
        end
      end
    end
    chk("resp_timeout", 32'(done), 32'd1);
    mem_ack = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem_model[a] = 8'($urandom);
    mem_model[10'h041] = 8'hAB;
    mem_model[{8'h40, 2'd3}] = 8'hC3;
    model_reset();

    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    do_req(1'b0, 1, 8'h10, 8'h00, 0);
    chk("s1_rf_addr", 32'(last_rf_addr), 32'h041);
    chk("s1_miss", 32'(last_hit), 32'd0);
    chk("s1_rdata", 32'(last_rdata), 32'hAB);
    do_req(1'b0, 1, 8'h10, 8'h00, 0);
    chk("s1_hit", 32'(last_hit), 32'd1);
    chk("s1_hit_lat", 32'(last_lat), 32'd2);

    do_req(1'b1, 2, 8'h20, 8'h55, 0);
    chk("s2_miss_a", 32'(last_hit), 32'd0);
    do_req(1'b1, 2, 8'h21, 8'h66, 0);
    chk("s2_miss_b", 32'(last_hit), 32'd0);

    do_req(1'b0, 2, 8'h20, 8'h00, 0);
    chk("s3_hit", 32'(last_hit), 32'd1);
    chk("s3_rdata", 32'(last_rdata), 32'h55);
    do_req(1'b1, 2, 8'h22, 8'h77, 1);
    chk("s3_wb_addr", 32'(last_wb_addr), 32'h086);
    chk("s3_wb_data", 32'(last_wb_data), 32'h66);
    do_req(1'b0, 2, 8'h22, 8'h00, 0);
    chk("s3_hit2", 32'(last_hit), 32'd1);
    chk("s3_rdata2", 32'(last_rdata), 32'h77);

    do_req(1'b0, 0, 8'h50, 8'h00, 5);
    chk("s4_miss", 32'(last_hit), 32'd0);

    // Abort a write-back with reset; the dirty victim never reaches memory.
    do_req(1'b1, 3, 8'h40, 8'h11, 0);
    do_req(1'b1, 3, 8'h41, 8'h22, 0);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_index = 2'd3; req_tag = 8'h42; req_wdata = 8'h33;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 10 && !mem_req; c++) @(negedge clock);
    chk("s5_wb_open", 32'(mem_req & mem_we), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("s5_mem_req_drop", 32'(mem_req), 32'd0);
    chk("s5_ready", 32'(req_ready), 32'd1);
    chk("s5_no_resp", 32'(resp_valid), 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    do_req(1'b0, 3, 8'h40, 8'h00, 1);
    chk("s5_miss", 32'(last_hit), 32'd0);
    chk("s5_rdata", 32'(last_rdata), 32'hC3);

    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             8'(8'h60 + $urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)));
    end

`ifdef CACHE_STATS_EN
    chk("hit_count", 32'(hit_count), 32'(hits_m));
    chk("miss_count", 32'(miss_count), 32'(misses_m));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
